// File: rtl/sd_spi_test_ctrl.sv
// sd_spi_test_ctrl: writes N_BLOCKS patterned sectors, reads them back and counts mismatches
module sd_spi_test_ctrl #(
  parameter logic [31:0] START_ADDR    = 32'd2000,
  parameter logic [7:0]  N_BLOCKS      = 8'd4,
  parameter logic [8:0]  WORDS_PER_BLK = 9'd256,
  parameter logic [23:0] TIMEOUT       = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sd_init_done,
  output logic        wr_start,
  output logic [31:0] wr_sec_addr,
  input  logic        wr_req,
  output logic [15:0] wr_data,
  input  logic        wr_busy,
  output logic        rd_start,
  output logic [31:0] rd_sec_addr,
  input  logic        rd_val_en,
  input  logic [15:0] rd_val_data,
  input  logic        rd_busy,
  output logic        error_flag,
  output logic        test_done,
  output logic [15:0] err_cnt
);
  typedef enum logic [2:0] {IDLE, WR_GO, WR_RUN, RD_GO, RD_RUN, DONE} state_t;
  state_t state, state_n;
  logic [7:0] blk, blk_n;
  logic [8:0] k, k_n;
  logic [23:0] tmo, tmo_n;
  logic wr_busy_q, rd_busy_q;
  logic wr_start_n, rd_start_n, error_flag_n, test_done_n;
  logic [31:0] wr_sec_addr_n, rd_sec_addr_n;
  logic [15:0] wr_data_n, err_cnt_n;
  logic [1:0] inc;
  logic [16:0] err_sum;
  logic clr, rd, word, fall, last;
  // next-state, counters and error accounting for the current cycle
  always_comb begin
    state_n = state;
    blk_n = blk;
    k_n = k;
    tmo_n = tmo;
    wr_start_n = 1'b0;
    rd_start_n = 1'b0;
    wr_sec_addr_n = wr_sec_addr;
    rd_sec_addr_n = rd_sec_addr;
    wr_data_n = wr_data;
    error_flag_n = error_flag;
    test_done_n = test_done;
    inc = 2'd0;
    clr = 1'b0;
    rd = state == RD_GO || state == RD_RUN;
    word = rd ? rd_val_en : wr_req;
    fall = rd ? rd_busy_q & ~rd_busy : wr_busy_q & ~wr_busy;
    last = blk == N_BLOCKS - 8'd1;
    unique case (state)
      IDLE: if (sd_init_done) begin
        clr = 1'b1;
        error_flag_n = 1'b0;
        test_done_n = 1'b0;
        blk_n = 8'd0;
        state_n = WR_GO;
      end
      WR_GO, RD_GO: if (!sd_init_done) state_n = IDLE;
      else begin
        wr_start_n = !rd;
        rd_start_n = rd;
        if (rd) rd_sec_addr_n = START_ADDR + {24'd0, blk};
        else begin
          wr_sec_addr_n = START_ADDR + {24'd0, blk};
          wr_data_n = {blk, 8'd0};
        end
        k_n = 9'd0;
        tmo_n = 24'd0;
        state_n = rd ? RD_RUN : WR_RUN;
      end
      WR_RUN, RD_RUN: if (!sd_init_done) state_n = IDLE;
      else begin
        if (word && k < WORDS_PER_BLK) begin
          k_n = k + 9'd1;
          if (!rd) wr_data_n = {blk, k_n[7:0]};
          else if (rd_val_data != {blk, k[7:0]}) inc = inc + 2'd1;
        end else if (word) inc = inc + 2'd1;
        tmo_n = tmo + 24'd1;
        if (fall) begin
          if (k_n != WORDS_PER_BLK) inc = inc + 2'd1;
          blk_n = last ? 8'd0 : blk + 8'd1;
          state_n = last ? (rd ? DONE : RD_GO) : (rd ? RD_GO : WR_GO);
          if (rd && last) test_done_n = 1'b1;
        end else if (tmo == TIMEOUT - 24'd1) begin
          inc = inc + 2'd1;
          test_done_n = 1'b1;
          state_n = DONE;
        end
      end
      DONE: if (!sd_init_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    err_sum = {1'b0, err_cnt} + {15'd0, inc};
    err_cnt_n = clr ? 16'd0 : err_sum[16] ? 16'hFFFF : err_sum[15:0];
    if (inc != 2'd0) error_flag_n = 1'b1;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      blk <= 8'd0;
      k <= 9'd0;
      tmo <= 24'd0;
      wr_busy_q <= 1'b0;
      rd_busy_q <= 1'b0;
      wr_start <= 1'b0;
      rd_start <= 1'b0;
      wr_sec_addr <= 32'd0;
      rd_sec_addr <= 32'd0;
      wr_data <= 16'd0;
      error_flag <= 1'b0;
      test_done <= 1'b0;
      err_cnt <= 16'd0;
    end else begin
      state <= state_n;
      blk <= blk_n;
      k <= k_n;
      tmo <= tmo_n;
      wr_busy_q <= wr_busy;
      rd_busy_q <= rd_busy;
      wr_start <= wr_start_n;
      rd_start <= rd_start_n;
      wr_sec_addr <= wr_sec_addr_n;
      rd_sec_addr <= rd_sec_addr_n;
      wr_data <= wr_data_n;
      error_flag <= error_flag_n;
      test_done <= test_done_n;
      err_cnt <= err_cnt_n;
    end
  end
endmodule

// File: tb/tb_sd_spi_test_ctrl.sv
// tb_sd_spi_test_ctrl: randomized writer/reader models checked against a block-level error model
module tb_sd_spi_test_ctrl;
  localparam int W = 4;
  localparam int NB = 2;
  localparam int TMO = 100;
  localparam logic [31:0] SA = 32'd2000;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sd_init_done = 1'b0;
  logic wr_req = 1'b0;
  logic wr_busy = 1'b0;
  logic rd_val_en = 1'b0;
  logic rd_busy = 1'b0;
  logic [15:0] rd_val_data = 16'd0;
  logic wr_start, rd_start, error_flag, test_done;
  logic [31:0] wr_sec_addr, rd_sec_addr;
  logic [15:0] wr_data, err_cnt;
  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int cfg_nw[NB];
  int cfg_nr[NB];
  logic [W-1:0] cfg_bad[NB];
  logic [15:0] cfg_xv;

  sd_spi_test_ctrl #(
    .START_ADDR(SA), .N_BLOCKS(8'd2), .WORDS_PER_BLK(9'd4), .TIMEOUT(24'd100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sd_init_done(sd_init_done),
    .wr_start(wr_start), .wr_sec_addr(wr_sec_addr), .wr_req(wr_req), .wr_data(wr_data), .wr_busy(wr_busy),
    .rd_start(rd_start), .rd_sec_addr(rd_sec_addr), .rd_val_en(rd_val_en), .rd_val_data(rd_val_data),
    .rd_busy(rd_busy), .error_flag(error_flag), .test_done(test_done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_start) wr_pulses <= wr_pulses + 1;
    if (rd_start) rd_pulses <= rd_pulses + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  function automatic logic [15:0] pat(input int b, input int k);
    return 16'((b % 256) * 256 + (k % 256));
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_pulses"}, 64'({wr_start, rd_start}), 64'(0));
    chk({t, "_addrs"}, {wr_sec_addr, rd_sec_addr}, 64'(0));
    chk({t, "_data"}, 64'(wr_data), 64'(0));
    chk({t, "_status"}, 64'({error_flag, test_done, err_cnt}), 64'(0));
  endtask

  task automatic wait_pulse(input bit wr, output logic [31:0] addr, output bit ok);
    ok = 1'b0;
    addr = 32'd0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (wr ? wr_start : rd_start) begin
        ok = 1'b1;
        addr = wr ? wr_sec_addr : rd_sec_addr;
      end
    end
    chk(wr ? "wr_pulse_seen" : "rd_pulse_seen", 64'(ok), 64'(1));
  endtask

  task automatic serve_write(input int b, input int n);
    bit co;
    int nerr;
    co = n >= 2 && $urandom_range(0, 1) == 1;
    nerr = (n > W ? n - W : 0) + (n < W ? 1 : 0);
    wr_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i < W) chk("wr_data", 64'(wr_data), 64'(pat(b, i)));
      wr_req = 1'b1;
      if (i == n - 1 && co) wr_busy = 1'b0;
      @(negedge clk);
      wr_req = 1'b0;
    end
    if (!co) begin
      repeat ($urandom_range(n == 0 ? 1 : 0, 2)) @(negedge clk);
      wr_busy = 1'b0;
      @(negedge clk);
    end
    exp_err += nerr;
    chk("wr_blk_err", 64'(err_cnt), 64'(exp_err));
    chk("wr_blk_flag", 64'(error_flag), 64'(exp_err != 0));
  endtask

  task automatic serve_read(input int b, input int n, input logic [W-1:0] bad, input logic [15:0] xv);
    bit co;
    int nerr;
    co = n >= 2 && $urandom_range(0, 1) == 1;
    nerr = (n > W ? n - W : 0) + (n < W ? 1 : 0);
    rd_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rd_val_data = pat(b, i);
      if (i < W && bad[i]) begin
        rd_val_data = rd_val_data ^ (xv != 16'd0 ? xv : 16'($urandom_range(1, 65535)));
        nerr++;
      end
      rd_val_en = 1'b1;
      if (i == n - 1 && co) rd_busy = 1'b0;
      @(negedge clk);
      rd_val_en = 1'b0;
    end
    if (!co) begin
      repeat ($urandom_range(n == 0 ? 1 : 0, 2)) @(negedge clk);
      rd_busy = 1'b0;
      @(negedge clk);
    end
    exp_err += nerr;
    chk("rd_blk_err", 64'(err_cnt), 64'(exp_err));
    chk("rd_blk_flag", 64'(error_flag), 64'(exp_err != 0));
  endtask

  task automatic set_nominal();
    for (int b = 0; b < NB; b++) begin
      cfg_nw[b] = W;
      cfg_nr[b] = W;
      cfg_bad[b] = '0;
    end
    cfg_xv = 16'd0;
  endtask

  task automatic run_test();
    logic [31:0] a;
    bit ok;
    int wp0, rp0;
    exp_err = 0;
    wp0 = wr_pulses;
    rp0 = rd_pulses;
    sd_init_done = 1'b1;
    for (int b = 0; b < NB; b++) begin
      wait_pulse(1'b1, a, ok);
      if (!ok) begin
        sd_init_done = 1'b0;
        return;
      end
      chk("wr_addr", 64'(a), 64'(SA + 32'(b)));
      if (b == 0) begin
        chk("start_err_clr", 64'(err_cnt), 64'(0));
        chk("start_flag_clr", 64'(error_flag), 64'(0));
        chk("start_done_clr", 64'(test_done), 64'(0));
      end
      serve_write(b, cfg_nw[b]);
    end
    for (int b = 0; b < NB; b++) begin
      wait_pulse(1'b0, a, ok);
      if (!ok) begin
        sd_init_done = 1'b0;
        return;
      end
      chk("rd_addr", 64'(a), 64'(SA + 32'(b)));
      serve_read(b, cfg_nr[b], cfg_bad[b], cfg_xv);
    end
    chk("test_done", 64'(test_done), 64'(1));
    repeat (5) @(negedge clk);
    chk("wr_pulse_cnt", 64'(wr_pulses - wp0), 64'(NB));
    chk("rd_pulse_cnt", 64'(rd_pulses - rp0), 64'(NB));
    chk("done_err", 64'(err_cnt), 64'(exp_err));
    chk("done_flag", 64'(error_flag), 64'(exp_err != 0));
    sd_init_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_hold", 64'(test_done), 64'(1));
  endtask

  initial begin
    logic [31:0] a;
    bit ok;
    int n, wp0, rp0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    set_nominal();
    run_test();
    chk("nominal_err", 64'(err_cnt), 64'(0));

    set_nominal();
    cfg_bad[1] = 4'b0100;
    cfg_xv = 16'h0E00;
    run_test();
    chk("corrupt_err", 64'(err_cnt), 64'(1));
    chk("corrupt_flag", 64'(error_flag), 64'(1));

    set_nominal();
    cfg_nw[0] = 3;
    run_test();
    chk("short_wr_err", 64'(err_cnt), 64'(1));

    exp_err = 0;
    sd_init_done = 1'b1;
    for (int b = 0; b < NB; b++) begin
      wait_pulse(1'b1, a, ok);
      serve_write(b, W);
    end
    wait_pulse(1'b0, a, ok);
    n = 0;
    while (!error_flag && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 64'(n), 64'(TMO));
    chk("tmo_err", 64'(err_cnt), 64'(1));
    chk("tmo_done", 64'(test_done), 64'(1));
    rp0 = rd_pulses;
    repeat (20) @(negedge clk);
    chk("tmo_no_pulse", 64'(rd_pulses - rp0), 64'(0));
    sd_init_done = 1'b0;
    repeat (3) @(negedge clk);

    exp_err = 0;
    sd_init_done = 1'b1;
    wait_pulse(1'b1, a, ok);
    serve_write(0, W + 1);
    wait_pulse(1'b1, a, ok);
    chk("abort_addr1", 64'(a), 64'(SA + 32'd1));
    wr_busy = 1'b1;
    wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    sd_init_done = 1'b0;
    wp0 = wr_pulses;
    rp0 = rd_pulses;
    repeat (10) @(negedge clk);
    chk("abort_no_pulse", 64'((wr_pulses - wp0) + (rd_pulses - rp0)), 64'(0));
    chk("abort_err_hold", 64'(err_cnt), 64'(1));
    chk("abort_flag_hold", 64'(error_flag), 64'(1));
    chk("abort_not_done", 64'(test_done), 64'(0));
    wr_busy = 1'b0;
    set_nominal();
    run_test();
    chk("abort_rerun_err", 64'(err_cnt), 64'(0));

    exp_err = 0;
    sd_init_done = 1'b1;
    for (int b = 0; b < NB; b++) begin
      wait_pulse(1'b1, a, ok);
      serve_write(b, W);
    end
    wait_pulse(1'b0, a, ok);
    serve_read(0, W, 4'b0010, 16'd0);
    wait_pulse(1'b0, a, ok);
    rd_busy = 1'b1;
    rd_val_en = 1'b1;
    rd_val_data = pat(1, 0);
    @(negedge clk);
    rd_val_en = 1'b0;
    chk("pre_rst_flag", 64'(error_flag), 64'(1));
    reset_n = 1'b0;
    @(negedge clk);
    chk_zero("mid_rst");
    reset_n = 1'b1;
    rd_busy = 1'b0;
    set_nominal();
    run_test();
    chk("rst_rerun_err", 64'(err_cnt), 64'(0));

    for (int r = 0; r < 12; r++) begin
      for (int b = 0; b < NB; b++) begin
        cfg_nw[b] = $urandom_range(0, 3) == 0 ? int'($urandom_range(W - 2, W + 2)) : W;
        cfg_nr[b] = $urandom_range(0, 3) == 0 ? int'($urandom_range(W - 2, W + 2)) : W;
        cfg_bad[b] = $urandom_range(0, 2) == 0 ? W'($urandom_range(1, 15)) : '0;
      end
      cfg_xv = 16'd0;
      run_test();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
